// File: rtl/conv_result_pack.sv
// Scales 20-bit convolution results to saturated 8-bit pixels, packs four per word and
// streams the words out of a show-ahead FIFO tagged with a word address and end-of-frame.
module conv_result_pack #(
   parameter int unsigned SHIFT      = 4,
   parameter int unsigned IMG_W      = 510,
   parameter int unsigned IMG_H      = 510,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   input  logic [19:0] result,
   output logic        o_valid,
   input  logic        o_ready,
   output logic [31:0] o_data,
   output logic [15:0] o_addr,
   output logic        o_last,
   output logic        frame_done,
   output logic        overflow
);

   localparam int unsigned NUM_PIX  = IMG_W * IMG_H;
   localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [17:0] LAST_PIX = 18'(NUM_PIX - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic               accept;
   logic signed [19:0] shifted;
   logic [7:0]         pix_d, pix_q;
   logic               pix_vld_q, pix_last_q;
   logic [17:0]        pix_cnt_q;
   logic [1:0]         lane_q;
   logic [23:0]        pack_q;
   logic [31:0]        word_q;
   logic [15:0]        word_addr_q, addr_q;
   logic               word_last_q, push_q;
   logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
   logic [PTR_W-1:0]   wr_idx, rd_idx;
   logic               empty, full, pop, do_push;
   logic               overflow_q;

   logic [31:0] mem_data [FIFO_DEPTH];
   logic [15:0] mem_addr [FIFO_DEPTH];
   logic        mem_last [FIFO_DEPTH];

   assign accept  = i_en && ((state_q == ST_IDLE) || (state_q == ST_RUN));
   assign shifted = $signed(result) >>> SHIFT;

   always_comb begin
      if (shifted < 0)               pix_d = 8'd0;
      else if (shifted > 20'sd255)   pix_d = 8'd255;
      else                           pix_d = shifted[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_q      <= 8'd0;
         pix_vld_q  <= 1'b0;
         pix_last_q <= 1'b0;
         pix_cnt_q  <= 18'd0;
      end else begin
         pix_vld_q <= accept;
         if (accept) begin
            pix_q      <= pix_d;
            pix_last_q <= (pix_cnt_q == LAST_PIX);
            pix_cnt_q  <= pix_cnt_q + 18'd1;
         end
      end
   end

   // Lane 3 goes straight into the word register so the pack register is free next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q      <= 2'd0;
         pack_q      <= 24'd0;
         word_q      <= 32'd0;
         word_addr_q <= 16'd0;
         word_last_q <= 1'b0;
         push_q      <= 1'b0;
         addr_q      <= 16'd0;
      end else begin
         push_q <= pix_vld_q && (lane_q == 2'd3);
         if (pix_vld_q) begin
            lane_q <= lane_q + 2'd1;
            unique case (lane_q)
               2'd0: pack_q[7:0]   <= pix_q;
               2'd1: pack_q[15:8]  <= pix_q;
               2'd2: pack_q[23:16] <= pix_q;
               2'd3: begin
                  word_q      <= {pix_q, pack_q};
                  word_addr_q <= addr_q;
                  word_last_q <= pix_last_q;
                  addr_q      <= addr_q + 16'd1;
               end
               default: ;
            endcase
         end
      end
   end

   assign wr_idx  = wr_ptr_q[PTR_W-1:0];
   assign rd_idx  = rd_ptr_q[PTR_W-1:0];
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
   assign o_valid = !empty && (state_q != ST_DONE);
   assign pop     = o_valid && o_ready;
   assign do_push = push_q && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_q && full && !pop) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_data[wr_idx] <= word_q;
         mem_addr[wr_idx] <= word_addr_q;
         mem_last[wr_idx] <= word_last_q;
      end
   end

   // Gated so storage contents never leak onto the port while empty or in reset.
   assign o_data     = o_valid ? mem_data[rd_idx] : 32'd0;
   assign o_addr     = o_valid ? mem_addr[rd_idx] : 16'd0;
   assign o_last     = o_valid ? mem_last[rd_idx] : 1'b0;
   assign frame_done = (state_q == ST_DONE);
   assign overflow   = overflow_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (i_en) state_d = ST_RUN;
         ST_RUN:   if (accept && (pix_cnt_q == LAST_PIX)) state_d = ST_DRAIN;
         ST_DRAIN: if (pop && mem_last[rd_idx]) state_d = ST_DONE;
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

endmodule

// File: doc/conv_result_pack.md
Name: conv_result_pack

Overview:
Downstream stage of the 3x3 line-buffered convolution core. It takes each 20-bit convolution result strobed by the core's output enable and scales it to an 8-bit pixel with saturation. It packs four pixels into a 32-bit word and buffers the words in a small FIFO. Words leave on a valid/ready write port with a word address. It also counts the frame and raises a frame-complete flag once the last word has been accepted.

Parameters:
SHIFT, 4, arithmetic right shift applied to result before clamping
IMG_W, 510, output pixels per row
IMG_H, 510, output rows per frame
FIFO_DEPTH, 8, word FIFO entries (power of two)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
i_en  input  1  one-cycle strobe; result is valid this cycle
result  input  20  two's-complement convolution result
o_valid  output  1  o_data/o_addr/o_last valid (FIFO non-empty)
o_ready  input  1  consumer accepts the word when o_valid && o_ready
o_data  output  32  packed pixels; pixel n of group in bits [8n+7:8n]
o_addr  output  16  word address, 0 .. IMG_W*IMG_H/4-1
o_last  output  1  high with the final word of the frame
frame_done  output  1  high after the last word is accepted; held until rst
overflow  output  1  sticky; a completed word was dropped because the FIFO was full

Behaviour:
- Reset (async, rst=1): all outputs 0. FIFO is emptied. Pixel counter, byte lane, word address and FSM return to IDLE.
- Scaling: s = result >>> SHIFT (sign-extended). Pixel = 0 if s<0, 255 if s>255, else s[7:0]. The scaled pixel is registered, giving 1 cycle of latency.
- Packing: byte lane counter 0..3, advanced on each accepted pixel. Lane 0 fills bits [7:0].
- When lane 3 is written, the word is pushed to the FIFO on the following cycle. The pack register is reused immediately, so back-to-back i_en every cycle is supported.
- Packing is continuous across rows; no per-row padding. IMG_W*IMG_H must be divisible by 4, giving 65025 words for the defaults.
- Pixel counter is 18 bits, 0 .. IMG_W*IMG_H-1. The word carrying the final pixel is tagged last, and o_last is stored in the FIFO with it.
- o_addr is stored per FIFO entry. It increments by 1 per pushed word, not per popped word, so dropped words leave an address gap.
- FIFO is show-ahead: o_data/o_addr/o_last present the head entry whenever o_valid=1.
- Outputs hold stable while o_valid=1 and o_ready=0.
- Full FIFO with a push due:
  - If a pop occurs the same cycle, the push proceeds and there is no overflow.
  - Otherwise the word is dropped, overflow is set to 1 and held until rst, and counting continues.
- FSM:
  - IDLE: waits for the first i_en, then goes to RUN; that pixel is processed.
  - RUN: goes to DRAIN after the final pixel is accepted.
  - DRAIN: further i_en is ignored. Goes to DONE when the last-tagged word is popped (o_valid & o_ready & o_last).
  - DONE: frame_done=1. All i_en ignored, o_valid=0. Only rst leaves DONE.
- i_en while no result is expected (DRAIN/DONE) has no effect.
- Reset mid-frame discards partial words and FIFO contents; the next frame restarts at o_addr=0, lane 0.

Test Plan:
1. Clamp and pack, SHIFT=4, o_ready=1:
   - Stimulus: results 0x00010, 0xFFFF0, 0x0FFFF, 0x00FF0 on consecutive i_en.
   - Required: one word o_data=0xFFFF0001 at o_addr=0, o_valid high for exactly 1 cycle.
2. Full frame, o_ready=1, i_en every 25 cycles, 260100 ramp results:
   - Required: 65025 words with addresses 0..65024 in order, o_last only on addr 65024.
   - Required: frame_done rises within 4 cycles of the last i_en; overflow=0.
3. Backpressure, o_ready=0, 32 back-to-back pixels:
   - Required: 8 words queued, o_valid=1, head word stable.
   - Then 4 more pixels: overflow=1, that word is dropped.
   - Then o_ready=1: 8 words drain in order at addresses 0..7, and the next word appears at addr 9.
4. FIFO full with o_ready=1 asserted on the cycle a 9th word completes: the word is accepted, overflow stays 0.
5. Reset mid-frame: rst after 1000 pixels gives all outputs 0. Then 4 pixels produce a word at o_addr=0.
6. After frame_done: 10 further i_en pulses leave o_valid=0, frame_done=1 and overflow unchanged.
